// File: rtl/cell2_bist_driver.sv
// Self-test driver for a 2-input cell: sweeps A/B, samples Y, tallies mismatches.
// Define BIST_GRAY_SEQ_EN for Gray-order vectors (00,01,11,10); default is binary.
module cell2_bist_driver #(
  parameter int          SETTLE_CYC = 2,
  parameter logic [3:0]  TRUTH      = 4'b0111,
  parameter int          PASSES     = 4,
  parameter int          CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             Y,
  output logic             A,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [1:0]       FAIL_VEC,
  output logic             FAIL_VLD
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] S_LAST =
    SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [PW-1:0] P_LAST = PW'(PASSES - 1);

  typedef enum logic [2:0] {
    IDLE, APPLY, SETTLE, SAMPLE, FINISH
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [1:0]    v;
  logic [PW-1:0] p;
  logic [SW-1:0] scnt;
  logic [1:0]    vec;
  logic          miss;
  logic          last;

`ifdef BIST_GRAY_SEQ_EN
  assign vec = {v[1], v[1] ^ v[0]};
`else
  assign vec = v;
`endif

  assign miss = (Y != TRUTH[{A, B}]);
  assign last = (v == 2'd3) && (p == P_LAST);

  always_comb begin
    nxt  = state;
    BUSY = 1'b1;
    DONE = 1'b0;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) nxt = APPLY;
      end
      APPLY:   nxt = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (scnt == S_LAST) nxt = SAMPLE;
      SAMPLE:  nxt = last ? FINISH : APPLY;
      FINISH: begin
        DONE = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      A        <= 1'b0;
      B        <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_VEC <= 2'b00;
      FAIL_VLD <= 1'b0;
      v        <= 2'd0;
      p        <= '0;
      scnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            PASS     <= 1'b0;
            ERR_CNT  <= '0;
            FAIL_VEC <= 2'b00;
            FAIL_VLD <= 1'b0;
            v        <= 2'd0;
            p        <= '0;
          end
        end
        APPLY: begin
          {A, B} <= vec;
          scnt   <= '0;
        end
        SETTLE: scnt <= scnt + 1'b1;
        SAMPLE: begin
          if (miss) begin
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
            if (!FAIL_VLD) begin
              FAIL_VEC <= {A, B};
              FAIL_VLD <= 1'b1;
            end
          end
          if (!last) begin
            v <= v + 2'd1;
            if (v == 2'd3) p <= p + 1'b1;
          end
        end
        // ERR_CNT already holds the final sample's contribution here
        FINISH: PASS <= (ERR_CNT == '0);
        default: ;
      endcase
    end
  end

endmodule
